program_loader: RTL and testbench

//  Byte-stream boot loader that fills the instruction memory through its write port
//  (writeAddress/writeData/writeEnable) before the processor starts fetching.

---
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream and writes 16-bit words
// into instruction memory while holding the core in reset.
module program_loader #(
  parameter int         ADDR_W = 20,
  parameter int         DATA_W = 16,
  parameter logic [7:0] MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic              rxReady,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic              loading,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        hdr_q, hdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              take;
  logic [ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0] cnt_sh;

  // Header fields are 24 bits; shifting keeps only the low ADDR_W.
  assign addr_sh = {addr_q[ADDR_W-9:0], rxData};
  assign cnt_sh  = {cnt_q[ADDR_W-9:0], rxData};
  assign take    = rxValid && (state_q != WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      we_q    <= we_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    we_d    = 1'b0;
    load_d  = load_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (take) begin
          if (rxData == MAGIC) begin
            state_d = HDR;
            hdr_d   = '0;
            load_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (take) begin
          hdr_d = hdr_q + 3'd1;
          if (hdr_q < 3'd3) addr_d = addr_sh;
          else              cnt_d  = cnt_sh;
          if (hdr_q == 3'd5) begin
            if (cnt_sh == '0) begin
              state_d = DONE;
              load_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = DATA_HI;
            end
          end
        end
      end
      DATA_HI: begin
        if (take) begin
          data_d  = {rxData, data_q[7:0]};
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (take) begin
          data_d  = {data_q[15:8], rxData};
          state_d = WRITE;
          we_d    = 1'b1;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - ADDR_W'(1);
        if (cnt_q == ADDR_W'(1)) begin
          state_d = DONE;
          load_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DATA_HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a pure state decode, held low while in reset.
  assign rxReady      = rst_n && (state_q != WRITE);
  assign writeAddress = addr_q;
  assign writeData    = data_q;
  assign writeEnable  = we_q;
  assign loading      = load_q;
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frames are driven byte by
// byte and observed writes are compared with a frame-level model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxData = '0;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic [19:0] writeAddress;
  logic [15:0] writeData;
  logic        writeEnable;
  logic        loading;
  logic        done;
  logic        error;

  program_loader dut (
    .clk(clk),
    .rst_n(rst_n),
    .rxData(rxData),
    .rxValid(rxValid),
    .rxReady(rxReady),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .writeEnable(writeEnable),
    .loading(loading),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          bad_rdy = 0;
  bit          gaps = 1'b0;
  logic [35:0] got[$];
  logic [35:0] exp_q[$];
  logic [15:0] wq[$];
  logic [15:0] mem[int];

  // Memory side: capture writes; ready must be low exactly when writing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (writeEnable) begin
        got.push_back({writeAddress, writeData});
        mem[int'(writeAddress)] = writeData;
      end
      if (rxReady == writeEnable) bad_rdy++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte timeout: rxReady=%b required 1", rxReady);
    end
    @(negedge clk);
    rxValid = 1'b0;
    rxData  = 8'($urandom);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // Model: word i of the frame lands at (ADDR + i) mod 2^20.
  task automatic send_frame(input logic [23:0] a, input logic [23:0] c);
    got.delete();
    exp_q.delete();
    foreach (wq[i]) exp_q.push_back({a[19:0] + 20'(i), wq[i]});
    send_byte(8'hA5);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(c[23:16]);
    send_byte(c[15:8]);
    send_byte(c[7:0]);
    foreach (wq[i]) begin
      send_byte(wq[i][15:8]);
      send_byte(wq[i][7:0]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [44:0] o;
    repeat (2) @(negedge clk);
    o = {rxReady, writeAddress, writeData, writeEnable, loading, done, error};
    vectors++;
    if (o !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h required 0", o);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rxReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release rxReady=%b required 1", rxReady);
    end
    gaps = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    vectors++;
    if ({loading, writeAddress} !== {1'b1, 20'hABCDE}) begin
      miscompares++;
      $display("FAIL hdr_load loading=%b addr=%h required 1 abcde",
               loading, writeAddress);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    o = {rxReady, writeAddress, writeData, writeEnable, loading, done, error};
    vectors++;
    if (o !== 45'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h required 0", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rxReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release2 rxReady=%b required 1", rxReady);
    end
  endtask

  task automatic test_basic();
    gaps = 1'b0;
    wq = '{16'h1234, 16'hABCD};
    send_frame(24'h001000, 24'h000002);
    vectors++;
    if (got.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_nwrites got %0d required %0d",
               got.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_write[%0d] got %h required %h",
                 i, got[i], exp_q[i]);
      end
    end
    vectors++;
    if ({mem[32'h1000], mem[32'h1001]} !== 32'h1234ABCD) begin
      miscompares++;
      $display("FAIL basic_fetch got %h required 1234abcd",
               {mem[32'h1000], mem[32'h1001]});
    end
    vectors++;
    if ({done, loading, error} !== 3'b100) begin
      miscompares++;
      $display("FAIL basic_status dle=%b required 100",
               {done, loading, error});
    end
  endtask

  task automatic test_bad_magic();
    pulse_reset();
    got.delete();
    send_byte(8'h5A);
    @(negedge clk);
    vectors++;
    if ({error, done, loading, 32'(got.size())} !== {3'b100, 32'd0}) begin
      miscompares++;
      $display("FAIL bad_magic edl=%b writes=%0d required 100 0",
               {error, done, loading}, got.size());
    end
    wq = '{16'($urandom)};
    send_frame(24'h000020, 24'h000001);
    vectors++;
    if (got.size() !== 1 || got[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL after_bad writes=%0d required 1 word %h",
               got.size(), exp_q[0]);
    end
    vectors++;
    if ({done, error} !== 2'b10) begin
      miscompares++;
      $display("FAIL error_clear de=%b required 10", {done, error});
    end
    got.delete();
    send_byte(8'h3C);
    @(negedge clk);
    vectors++;
    if ({done, error, 32'(got.size())} !== {2'b11, 32'd0}) begin
      miscompares++;
      $display("FAIL done_bad de=%b writes=%0d required 11 0",
               {done, error}, got.size());
    end
  endtask

  task automatic test_wrap();
    gaps = 1'b1;
    wq = '{16'h1111, 16'h2222};
    send_frame(24'h0FFFFF, 24'h000002);
    vectors++;
    if (got.size() !== 2) begin
      miscompares++;
      $display("FAIL wrap_nwrites got %0d required 2", got.size());
    end else foreach (exp_q[i]) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL wrap_write[%0d] got %h required %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cnt_zero();
    gaps = 1'b0;
    wq.delete();
    send_frame(24'h012345, 24'h000000);
    vectors++;
    if ({done, loading, 32'(got.size())} !== {2'b10, 32'd0}) begin
      miscompares++;
      $display("FAIL cnt_zero dl=%b writes=%0d required 10 0",
               {done, loading}, got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] a;
    gaps = 1'b1;
    got.delete();
    a = 24'($urandom);
    send_byte(8'hA5);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'($urandom));
    pulse_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({loading, done, error, 32'(got.size())} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_mid ldE=%b writes=%0d required 000 0",
               {loading, done, error}, got.size());
    end
    wq = '{16'($urandom), 16'($urandom), 16'($urandom)};
    send_frame(24'($urandom), 24'h000003);
    vectors++;
    if (got !== exp_q) begin
      miscompares++;
      $display("FAIL reset_mid_reload writes=%0d required %0d",
               got.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int          n;
    logic [23:0] c;
    for (int f = 0; f < 6; f++) begin
      gaps = f[0];
      n = $urandom_range(1, 6);
      c = {4'($urandom_range(0, 15)), 20'(n)};
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
      send_frame(24'($urandom), c);
      vectors++;
      if (got.size() !== n) begin
        miscompares++;
        $display("FAIL rand%0d_nwrites got %0d required %0d",
                 f, got.size(), n);
      end else foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_write[%0d] got %h required %h",
                   f, i, got[i], exp_q[i]);
        end
      end
      vectors++;
      if ({done, loading, error} !== 3'b100) begin
        miscompares++;
        $display("FAIL rand%0d_status dle=%b required 100",
                 f, {done, loading, error});
      end
    end
    vectors++;
    if (bad_rdy !== 0) begin
      miscompares++;
      $display("FAIL ready_only_in_write violations=%0d required 0",
               bad_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_magic();
    test_wrap();
    test_cnt_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
